// File: rtl/rsi_pkg.sv
// Shared constants, FSM encoding and saturation bounds
// for the RSI sliding-window sequencer.
package rsi_pkg;

    localparam int PERIOD = 14;
    localparam int DEPTH  = 20;
    localparam int WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EVICT  = 3'd1,
        RDWAIT = 3'd2,
        PUSH   = 3'd3,
        EMIT   = 3'd4
    } state_t;

    // Largest / smallest w-bit two's complement values
    function automatic longint sat_hi(int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/rsi_window_ctrl_if.sv
// Price input, FIFO side-band and update bundle
// shared between the sequencer and its neighbours.
interface rsi_window_ctrl_if #(
    parameter int WIDTH = rsi_pkg::WIDTH
);
    logic             flush;
    logic             price_valid;
    logic [WIDTH-1:0] price_in;
    logic             price_ready;
    logic             fifo_wr_en;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_din;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_clr;
    logic             upd_valid;
    logic [WIDTH-1:0] add_delta;
    logic             sub_en;
    logic [WIDTH-1:0] sub_delta;
    logic             window_full;
    logic             err;

    modport slave (
        input  flush, price_valid, price_in,
        input  fifo_dout, fifo_full, fifo_empty,
        output price_ready, fifo_wr_en, fifo_rd_en,
        output fifo_din, fifo_clr,
        output upd_valid, add_delta, sub_en,
        output sub_delta, window_full, err
    );

    modport master (
        output flush, price_valid, price_in,
        output fifo_dout, fifo_full, fifo_empty,
        input  price_ready, fifo_wr_en, fifo_rd_en,
        input  fifo_din, fifo_clr,
        input  upd_valid, add_delta, sub_en,
        input  sub_delta, window_full, err
    );

endinterface

// File: rtl/delta_sat.sv
// Unsigned price difference, widened by one bit and
// clamped back into W-bit signed range.
module delta_sat #(
    parameter int W = rsi_pkg::WIDTH
) (
    input  logic [W-1:0] price,
    input  logic [W-1:0] prev,
    output logic [W-1:0] delta
);
    localparam logic signed [W:0] HI =
        (W+1)'(rsi_pkg::sat_hi(W));
    localparam logic signed [W:0] LO =
        (W+1)'(rsi_pkg::sat_lo(W));

    logic signed [W:0] diff;

    assign diff = $signed({1'b0, price})
                - $signed({1'b0, prev});

    always_comb begin
        delta = diff[W-1:0];
        if (diff > HI) begin
            delta = HI[W-1:0];
        end else if (diff < LO) begin
            delta = LO[W-1:0];
        end
    end

endmodule

// File: rtl/rsi_window_ctrl.sv
// Sliding-window sequencer: turns prices into deltas,
// keeps PERIOD of them in the FIFO and emits add/sub updates.
module rsi_window_ctrl #(
    parameter int PERIOD = rsi_pkg::PERIOD,
    parameter int DEPTH  = rsi_pkg::DEPTH,
    parameter int WIDTH  = rsi_pkg::WIDTH,
    parameter int CNT_W  = 5
) (
    input logic              clk,
    input logic              rst,
    rsi_window_ctrl_if.slave bus
);
    typedef rsi_pkg::state_t state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD);

    if (PERIOD < 1 || PERIOD > DEPTH
        || (2 ** CNT_W) <= PERIOD) begin : g_bad_cfg
        $error("rsi_window_ctrl: bad PERIOD/DEPTH/CNT_W");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             have_prev;
    logic             evict;
    logic             accept;
    logic             full_hit;
    logic [WIDTH-1:0] last_price;
    logic [WIDTH-1:0] new_delta;
    logic [WIDTH-1:0] old_delta;
    logic [WIDTH-1:0] delta;

    logic             ready_q;
    logic             wr_q;
    logic             rd_q;
    logic [WIDTH-1:0] din_q;
    logic             clr_q;
    logic             upd_q;
    logic [WIDTH-1:0] add_q;
    logic             sub_en_q;
    logic [WIDTH-1:0] sub_q;
    logic             full_q;
    logic             err_q;

    delta_sat #(.W(WIDTH)) u_sat (
        .price (bus.price_in),
        .prev  (last_price),
        .delta (delta)
    );

    assign accept   = bus.price_valid && ready_q;
    assign full_hit = (cnt == CNT_MAX);
    assign cnt_nxt  = (!evict && !full_hit)
                    ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= rsi_pkg::IDLE;
            cnt        <= '0;
            have_prev  <= 1'b0;
            evict      <= 1'b0;
            last_price <= '0;
            new_delta  <= '0;
            old_delta  <= '0;
            ready_q    <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            din_q      <= '0;
            clr_q      <= 1'b0;
            upd_q      <= 1'b0;
            add_q      <= '0;
            sub_en_q   <= 1'b0;
            sub_q      <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            clr_q <= 1'b0;
            upd_q <= 1'b0;
            if (bus.flush) begin
                // Drop whatever is in flight and restart priming
                state     <= rsi_pkg::IDLE;
                cnt       <= '0;
                have_prev <= 1'b0;
                evict     <= 1'b0;
                ready_q   <= 1'b1;
                clr_q     <= 1'b1;
                sub_en_q  <= 1'b0;
                full_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                unique case (state)
                    rsi_pkg::IDLE: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            last_price <= bus.price_in;
                            have_prev  <= 1'b1;
                            if (have_prev) begin
                                new_delta <= delta;
                                evict     <= full_hit;
                                ready_q   <= 1'b0;
                                if (full_hit) begin
                                    state <= rsi_pkg::EVICT;
                                    rd_q  <= 1'b1;
                                end else begin
                                    state <= rsi_pkg::PUSH;
                                    wr_q  <= 1'b1;
                                    din_q <= delta;
                                end
                            end
                        end
                    end
                    rsi_pkg::EVICT: begin
                        if (bus.fifo_empty) err_q <= 1'b1;
                        state <= rsi_pkg::RDWAIT;
                    end
                    rsi_pkg::RDWAIT: begin
                        old_delta <= bus.fifo_dout;
                        state     <= rsi_pkg::PUSH;
                        wr_q      <= 1'b1;
                        din_q     <= new_delta;
                    end
                    rsi_pkg::PUSH: begin
                        if (!evict && bus.fifo_full) begin
                            err_q <= 1'b1;
                        end
                        cnt      <= cnt_nxt;
                        full_q   <= (cnt_nxt == CNT_MAX);
                        upd_q    <= 1'b1;
                        add_q    <= new_delta;
                        sub_en_q <= evict;
                        sub_q    <= evict ? old_delta : '0;
                        state    <= rsi_pkg::EMIT;
                    end
                    rsi_pkg::EMIT: begin
                        sub_en_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= rsi_pkg::IDLE;
                    end
                    default: begin
                        state <= rsi_pkg::IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.price_ready = ready_q;
    assign bus.fifo_wr_en  = wr_q;
    assign bus.fifo_rd_en  = rd_q;
    assign bus.fifo_din    = din_q;
    assign bus.fifo_clr    = clr_q;
    assign bus.upd_valid   = upd_q;
    assign bus.add_delta   = add_q;
    assign bus.sub_en      = sub_en_q;
    assign bus.sub_delta   = sub_q;
    assign bus.window_full = full_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_rsi_window_ctrl.sv
// Directed bench for rsi_window_ctrl with PERIOD=3
// and a behavioural 20-deep registered-output FIFO.
module tb_rsi_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsi_window_ctrl_if #(.WIDTH(16)) bus ();

    rsi_window_ctrl #(
        .PERIOD (3),
        .DEPTH  (20),
        .WIDTH  (16),
        .CNT_W  (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural FIFO
    logic        force_empty = 1'b0;
    logic [15:0] mem [0:19];
    int          wp, rp, fcnt;
    logic [15:0] dout_q;

    always @(posedge clk or posedge rst) begin
        if (rst || bus.fifo_clr) begin
            wp <= 0; rp <= 0; fcnt <= 0; dout_q <= '0;
        end else begin
            if (bus.fifo_wr_en && fcnt < 20) begin
                mem[wp] <= bus.fifo_din;
                wp <= (wp + 1) % 20;
            end
            if (bus.fifo_rd_en && fcnt > 0) begin
                dout_q <= mem[rp];
                rp <= (rp + 1) % 20;
            end
            fcnt <= fcnt
                  + ((bus.fifo_wr_en && fcnt < 20) ? 1 : 0)
                  - ((bus.fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end

    assign bus.fifo_dout  = dout_q;
    assign bus.fifo_full  = (fcnt == 20);
    assign bus.fifo_empty = (fcnt == 0) || force_empty;

    typedef struct {
        int price;
        int upd;
        int add;
        int sub_en;
        int sub;
        int full;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(string name, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     name, got, exp);
        end
    endtask

    function automatic int sx(logic [15:0] v);
        return int'($signed(v));
    endfunction

    // One price, then watch six cycles for the update
    task automatic run_vec(vec_t v, string tag);
        int lat = 0;
        int n_upd = 0;
        int n_rd = 0;
        int g_add = 0;
        int g_sen = 0;
        int g_sub = 0;
        @(negedge clk);
        chk({tag, ".ready_pre"}, int'(bus.price_ready), 1);
        bus.price_valid = 1'b1;
        bus.price_in = 16'(v.price);
        @(negedge clk);
        bus.price_valid = 1'b0;
        chk({tag, ".ready_post"}, int'(bus.price_ready),
            v.upd ? 0 : 1);
        for (int i = 1; i <= 6; i++) begin
            if (bus.fifo_rd_en) n_rd++;
            if (bus.upd_valid) begin
                n_upd++;
                if (lat == 0) begin
                    lat = i;
                    g_add = sx(bus.add_delta);
                    g_sen = int'(bus.sub_en);
                    g_sub = sx(bus.sub_delta);
                end
            end
            if (i < 6) @(negedge clk);
        end
        chk({tag, ".n_upd"}, n_upd, v.upd);
        chk({tag, ".n_rd"}, n_rd, v.sub_en);
        if (v.upd != 0) begin
            chk({tag, ".lat"}, lat, v.sub_en ? 4 : 2);
            chk({tag, ".add"}, g_add, v.add);
            chk({tag, ".sub_en"}, g_sen, v.sub_en);
            chk({tag, ".sub"}, g_sub, v.sub);
        end
        chk({tag, ".full"}, int'(bus.window_full), v.full);
    endtask

    task automatic do_flush(string tag);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk({tag, ".clr"}, int'(bus.fifo_clr), 1);
        chk({tag, ".err"}, int'(bus.err), 0);
        chk({tag, ".full"}, int'(bus.window_full), 0);
    endtask

    initial begin
        int n_upd;
        int n_clr;
        int acc;
        int run;
        int runs [$];

        bus.flush = 1'b0;
        bus.price_valid = 1'b0;
        bus.price_in = '0;

        vecs[0] = '{100,   0, 0,      0, 0,  0};
        vecs[1] = '{103,   1, 3,      0, 0,  0};
        vecs[2] = '{101,   1, -2,     0, 0,  0};
        vecs[3] = '{106,   1, 5,      0, 0,  1};
        vecs[4] = '{104,   1, -2,     1, 3,  1};
        vecs[5] = '{110,   1, 6,      1, -2, 1};
        vecs[6] = '{0,     1, -110,   1, 5,  1};
        vecs[7] = '{65535, 1, 32767,  1, -2, 1};
        vecs[8] = '{0,     1, -32768, 1, 6,  1};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready", int'(bus.price_ready), 0);
        chk("rst.flags", int'({bus.fifo_wr_en,
            bus.fifo_rd_en, bus.fifo_clr, bus.upd_valid,
            bus.sub_en, bus.window_full, bus.err}), 0);
        chk("rst.din", int'(bus.fifo_din), 0);
        chk("rst.add", int'(bus.add_delta), 0);
        chk("rst.sub", int'(bus.sub_delta), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.ready_up", int'(bus.price_ready), 1);

        // Fill, evict, saturate
        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end
        chk("vec.err", int'(bus.err), 0);

        // Flush during EVICT, with a price in the flush cycle
        @(negedge clk);
        bus.price_valid = 1'b1;
        bus.price_in = 16'd7;
        @(negedge clk);
        chk("fl.evict_rd", int'(bus.fifo_rd_en), 1);
        bus.flush = 1'b1;
        bus.price_in = 16'd999;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.price_valid = 1'b0;
        chk("fl.clr", int'(bus.fifo_clr), 1);
        chk("fl.full", int'(bus.window_full), 0);
        chk("fl.ready", int'(bus.price_ready), 1);
        n_upd = 0;
        n_clr = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.upd_valid) n_upd++;
            @(negedge clk);
            if (bus.fifo_clr) n_clr++;
        end
        chk("fl.no_upd", n_upd, 0);
        chk("fl.clr_once", n_clr, 0);
        run_vec('{50, 0, 0, 0, 0, 0}, "fl50");
        run_vec('{55, 1, 5, 0, 0, 0}, "fl55");

        // Empty FIFO during EVICT sets sticky err
        run_vec('{60, 1, 5, 0, 0, 0}, "e60");
        run_vec('{65, 1, 5, 0, 0, 1}, "e65");
        chk("err.pre", int'(bus.err), 0);
        force_empty = 1'b1;
        run_vec('{70, 1, 5, 1, 5, 1}, "e70");
        force_empty = 1'b0;
        chk("err.set", int'(bus.err), 1);
        run_vec('{75, 1, 5, 1, 5, 1}, "e75");
        chk("err.sticky", int'(bus.err), 1);
        do_flush("err.flush");

        // Backpressure: price_valid held high
        acc = 0;
        run = 0;
        n_upd = 0;
        bus.price_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.upd_valid) n_upd++;
            if (bus.price_ready) begin
                if (run > 0) begin
                    runs.push_back(run);
                    run = 0;
                end
                acc++;
            end else begin
                run++;
            end
            bus.price_in = 16'(300 + 7 * c);
            @(negedge clk);
        end
        bus.price_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.upd_valid) n_upd++;
            @(negedge clk);
        end
        chk("bp.accepts", acc, 10);
        chk("bp.updates", n_upd, 9);
        chk("bp.runs", runs.size(), 8);
        foreach (runs[k]) begin
            chk($sformatf("bp.run%0d", k), runs[k],
                k < 3 ? 2 : 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rsi_window_ctrl.md
Name: rsi_window_ctrl

Overview:
- Sequencer in front of the price FIFO that maintains a sliding window of the last PERIOD price changes (deltas) for the RSI datapath.
- Accepts a raw price stream and computes delta = price − previous price, saturated to WIDTH bits signed.
- Pushes each delta into the FIFO. Once the window is full, it pops the oldest delta first.
- Emits one update per price: the delta to add and, when the window is full, the delta to subtract. The downstream gain/loss accumulators consume these updates.

Parameters:
- PERIOD, 14, RSI window length in deltas; must satisfy 1 ≤ PERIOD ≤ DEPTH.
- DEPTH, 20, depth of the attached FIFO.
- WIDTH, 16, price width and FIFO data width.
- CNT_W, 5, width of the window occupancy counter; must satisfy 2^CNT_W > PERIOD.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous window clear
- price_valid  in  1  input price strobe
- price_in  in  WIDTH  unsigned price
- price_ready  out  1  controller can accept a price
- fifo_wr_en  out  1  FIFO write enable
- fifo_rd_en  out  1  FIFO read enable
- fifo_din  out  WIDTH  signed delta to FIFO
- fifo_dout  in  WIDTH  FIFO read data; registered, valid the cycle after fifo_rd_en
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_clr  out  1  one-cycle pulse driving the FIFO reset
- upd_valid  out  1  update strobe, one cycle wide
- add_delta  out  WIDTH  signed newest delta
- sub_en  out  1  sub_delta is meaningful in this update
- sub_delta  out  WIDTH  signed evicted delta
- window_full  out  1  occupancy == PERIOD
- err  out  1  sticky protocol error

Behaviour:

Reset values:
- All outputs are 0.
- Internally: state = IDLE, cnt = 0, have_prev = 0, last_price = 0.

Arithmetic:
- delta is computed at WIDTH+1 bits signed as price_in − last_price.
- It is saturated to the range [−2^(WIDTH−1), 2^(WIDTH−1)−1] and stored as WIDTH bits two's complement.

States:
- IDLE
  - price_ready = 1.
  - On price_valid with have_prev = 0: latch last_price; set have_prev = 1; no update is emitted; stay in IDLE.
  - On price_valid with have_prev = 1: latch new_delta; set last_price ← price_in; set evict = (cnt == PERIOD).
  - Next state is EVICT if evict, else PUSH.
- EVICT: fifo_rd_en = 1 for exactly one cycle, then RDWAIT.
- RDWAIT: latch old_delta ← fifo_dout, then PUSH.
- PUSH
  - fifo_wr_en = 1 with fifo_din = new_delta.
  - cnt increments only when evict = 0; it saturates at PERIOD.
  - Next state is EMIT.
- EMIT
  - upd_valid = 1, add_delta = new_delta.
  - If evict: sub_en = 1 and sub_delta = old_delta; otherwise sub_en = 0 and sub_delta = 0.
  - Next state is IDLE.

Handshakes and timing:
- price_ready is low in every state except IDLE. A price_valid asserted while price_ready is low is ignored; it is not queued.
- Latency from the accept cycle T: upd_valid at T+2 without eviction, T+4 with eviction.
- Maximum throughput: one price per 3 cycles while filling, one per 5 cycles when full.
- window_full is registered and equals (cnt == PERIOD). It first rises in the cycle after the PERIOD-th PUSH.

Flush:
- flush has priority over everything except rst and works in any state.
- Next cycle: state = IDLE, cnt = 0, have_prev = 0, window_full = 0, upd_valid = 0, and fifo_clr = 1 for one cycle.
- Any in-flight update is dropped. A price_valid in the flush cycle is ignored.

Error detection:
- err is set if fifo_full = 1 in PUSH with evict = 0, or if fifo_empty = 1 in EVICT.
- err clears only on rst or flush.
- The FSM continues normally after err is set; the FIFO's own guards govern data in these cases.

Reset mid-operation:
- Asynchronous return to reset values.
- The FIFO is reset by the same rst at system level.

Decomposition:
- Package rsi_pkg holds:
  - the shared constants PERIOD, WIDTH and DEPTH;
  - the state encoding localparams IDLE, EVICT, RDWAIT, PUSH, EMIT;
  - the saturation bounds.
- Sub-module delta_sat: combinational (WIDTH+1)-bit subtract with saturation to WIDTH bits signed.
- The FSM, counter and registers stay in rsi_window_ctrl.

Test Plan (PERIOD = 3 for the bench, paired with a behavioural FIFO of DEPTH = 20):
- First price: rst, then price 100 → no upd_valid, price_ready stays 1, have_prev = 1.
- Fill: prices 100, 103, 101, 106 → upd_valid with add_delta = +3, −2, +5, sub_en = 0 each time, each at T+2; window_full rises after the third update.
- Eviction: next price 104 → fifo_rd_en pulse, then upd_valid at T+4 with add_delta = −2, sub_en = 1, sub_delta = +3; window_full stays 1 and cnt stays 3.
- Saturation: price 0 then 65535 → add_delta = 32767; price 65535 then 0 → add_delta = −32768.
- Flush mid-EVICT: assert flush during the EVICT cycle → no upd_valid, fifo_clr pulses once, window_full = 0; the next two prices 50 and 55 produce a single update with add_delta = +5, sub_en = 0.
- Error and backpressure:
  - Force fifo_empty = 1 during EVICT → err = 1 and stays 1 until flush.
  - Hold price_valid continuously → exactly one price is accepted per IDLE visit, and price_ready drops for 2 or 4 cycles after each accept.
